axi_pwm_lite_slave: RTL and testbench
=====================================

Name: axi_pwm_lite_slave

Overview:
- AXI4-Lite responder (slave) for the PWM generator IP.
- Terminates the AXI4-Lite port driven by the system master and the verification master agent.
- Holds four 32-bit read/write registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Drives a single PWM output from the CTRL, PERIOD and DUTY registers through period-synchronous shadow copies.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, AXI address width; word index is ADDR[3:2].
- CNT_WIDTH, 32, width of the PWM counter; PERIOD/DUTY use the low CNT_WIDTH bits.

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4  write data and byte strobes.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  4 / S_AXI_ARPROT  in  3 (ignored).
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read-address handshake.
- S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data channel.
- pwm_out  out  1  PWM waveform.

Behaviour:
- Reset (S_AXI_ARESETN low, asynchronous)
  - All registers, latches and counters clear to 0.
  - BVALID, RVALID, RDATA, BRESP, RRESP and pwm_out are 0.
  - AWREADY, WREADY and ARREADY are 0 while reset is asserted and go to 1 on the first cycle after release.
- Reset mid-transaction: any in-flight transaction is dropped with no response. The master must restart.
- Register map (ADDR[3:2])
  - 0 CTRL: bit0 enable, bit1 invert, bits[31:2] read/write scratch.
  - 1 PERIOD.
  - 2 DUTY.
  - 3 SCRATCH.
  - ADDR[1:0] is ignored.
  - Every register reads back exactly what was written; no reserved bits are masked.
- Write channel
  - AW and W are accepted independently.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - A handshake latches the address, or the data plus strobes, into its holding register.
  - When both are held (same cycle or different cycles), the register is updated on the next edge using byte-lane WSTRB. Bytes with strobe 0 are unchanged.
  - BVALID asserts on that same edge with BRESP=OKAY (2'b00), and the held flags clear.
  - BVALID holds until BREADY. No new AW or W is accepted while BVALID=1.
  - Minimum latency: AW and W together at edge N, register updated and BVALID high after edge N+1.
- Read channel
  - ARREADY = !RVALID.
  - On AR handshake at edge N, RDATA is loaded from the current register value, and RVALID=1 and RRESP=OKAY after edge N.
  - RDATA and RVALID hold until RREADY. The next AR is accepted the cycle after RVALID drops.
- Read/write collision: if a write commit and an AR handshake to the same word occur on the same edge, RDATA returns the pre-write value.
- Read and write channels operate concurrently.
- PWM
  - When CTRL.enable=0: counter held at 0, pwm_out=0, and shadow registers load PERIOD/DUTY every cycle.
  - When enabled, the counter runs 0..period_sh-1 and wraps to 0.
  - Shadow registers load from PERIOD/DUTY only on the wrap edge, so mid-period writes take effect at the next period.
  - Raw output = (cnt < duty_sh). pwm_out = enable && (raw XOR invert), registered (1-cycle latency).
  - period_sh=0: counter held at 0, raw=0.
  - duty_sh >= period_sh: raw is constantly 1.
  - duty_sh=0: raw is constantly 0.

Decomposition:
- Package axi_pwm_pkg
  - Register offset constants: REG_CTRL=0, REG_PERIOD=1, REG_DUTY=2, REG_SCRATCH=3.
  - CTRL bit indices: CTRL_EN=0, CTRL_INV=1.
  - RESP_OKAY=2'b00.
  - Write-state enum: IDLE, RESP.
- Sub-module: pwm_core. Contains the counter, shadow registers and output register. Inputs: enable, invert, period, duty. Output: pwm_out.

Test Plan:
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB=0xF, then read back -> RDATA 0x1, 0x2, 0x3, 0x4, all BRESP/RRESP=OKAY.
- AW presented 3 cycles before W; BREADY held low for 5 cycles -> AWREADY stays low until the B handshake, no second write accepted, BVALID held throughout, register updated once.
- Write 0xAABBCCDD to SCRATCH, then write 0x11223344 with WSTRB=0x5 -> readback 0xAA22CC44.
- PERIOD=10, DUTY=3, CTRL=0x1 -> pwm_out high 3 cycles and low 7 cycles repeating. Write DUTY=7 mid-period -> change appears at the next period start. Set CTRL=0x3 -> inverted waveform.
- Boundaries: DUTY=12 with PERIOD=10 -> pwm_out constant 1; PERIOD=0 -> constant 0; CTRL=0 -> pwm_out 0 and counter 0.
- Deassert S_AXI_ARESETN while BVALID=1 and RVALID=1 -> BVALID, RVALID and pwm_out drop immediately; all registers read 0 after reset release.

Source files
------------

// File: rtl/axi_pwm_pkg.sv
// Shared constants and types for the AXI4-Lite PWM slave.
package axi_pwm_pkg;

  localparam int NUM_REGS = 4;
  localparam int DATA_W   = 32;
  localparam int STRB_W   = DATA_W / 8;

  // Word indices (ADDR[3:2])
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_DUTY    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {IDLE, RESP} wr_state_e;

  // Write data held between the W handshake and the commit
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } w_hold_t;

  // Byte-lane merge of new data into an existing word
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM counter with period-synchronous shadow registers and registered output.
module pwm_core #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 invert,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] duty,
  output logic                 pwm_out
);

  logic [CNT_WIDTH-1:0] cnt, period_sh, duty_sh;
  logic                 wrap, raw;

  // A zero period wraps every cycle, so the counter stays at 0 and the
  // shadows keep tracking PERIOD/DUTY until a real period is programmed.
  assign wrap = (period_sh == '0) || (cnt == period_sh - CNT_WIDTH'(1));
  assign raw  = (period_sh != '0) && (cnt < duty_sh);

  // Period counter: held at 0 while disabled, wraps at period_sh-1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                cnt <= '0;
    else if (!enable || wrap)  cnt <= '0;
    else                       cnt <= cnt + CNT_WIDTH'(1);

  // Shadows follow the registers while disabled, else reload only at wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      period_sh <= '0;
      duty_sh   <= '0;
    end else if (!enable || wrap) begin
      period_sh <= period;
      duty_sh   <= duty;
    end

  // Registered output, forced low while disabled regardless of invert
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm_out <= 1'b0;
    else        pwm_out <= enable && (raw ^ invert);

endmodule

// File: rtl/axi_pwm_lite_slave.sv
// AXI4-Lite slave with four R/W registers driving a single PWM output.
module axi_pwm_lite_slave
  import axi_pwm_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            pwm_out
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  wr_state_e   wr_state, wr_state_n;
  logic        live;
  logic        aw_held, w_held;
  logic [1:0]  aw_idx;
  w_hold_t     w_hold;
  logic        commit, bvalid;
  logic        aw_hs, w_hs, ar_hs;
  logic        rvalid;
  logic [DATA_W-1:0] rdata;

  // Protection bits and the byte offset within a word carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies stay low during reset and rise on the first edge after release
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) live <= 1'b0;
    else                live <= 1'b1;

  assign S_AXI_AWREADY = live && !aw_held && !bvalid;
  assign S_AXI_WREADY  = live && !w_held  && !bvalid;
  assign S_AXI_ARREADY = live && !rvalid;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Address holding register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      aw_held <= 1'b0;
      aw_idx  <= '0;
    end else if (aw_hs) begin
      aw_held <= 1'b1;
      aw_idx  <= S_AXI_AWADDR[3:2];
    end else if (commit) begin
      aw_held <= 1'b0;
    end

  // Data/strobe holding register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      w_held <= 1'b0;
      w_hold <= '0;
    end else if (w_hs) begin
      w_held      <= 1'b1;
      w_hold.data <= S_AXI_WDATA;
      w_hold.strb <= S_AXI_WSTRB;
    end else if (commit) begin
      w_held <= 1'b0;
    end

  // Write FSM state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) wr_state <= IDLE;
    else                wr_state <= wr_state_n;

  // Write FSM next state: commit once both halves are held, wait for BREADY
  always_comb begin
    wr_state_n = wr_state;
    case (wr_state)
      IDLE:    if (aw_held && w_held) wr_state_n = RESP;
      RESP:    if (S_AXI_BREADY)      wr_state_n = IDLE;
      default: wr_state_n = IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    commit = (wr_state == IDLE) && aw_held && w_held;
    bvalid = (wr_state == RESP);
  end

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = RESP_OKAY;

  // Register file: byte-strobed commit of the held write
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN)
      regs <= '0;
    else if (commit)
      regs[aw_idx] <= strb_merge(regs[aw_idx], w_hold.data, w_hold.strb);

  // Read channel: capture the pre-commit value on the AR edge, hold to RREADY
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end

  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA  = rdata;
  assign S_AXI_RRESP  = RESP_OKAY;

  pwm_core #(.CNT_WIDTH(CNT_WIDTH)) u_pwm (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .enable  (regs[REG_CTRL][CTRL_EN]),
    .invert  (regs[REG_CTRL][CTRL_INV]),
    .period  (regs[REG_PERIOD][CNT_WIDTH-1:0]),
    .duty    (regs[REG_DUTY][CNT_WIDTH-1:0]),
    .pwm_out (pwm_out)
  );

endmodule

// File: tb/tb_axi_pwm_lite_slave.sv
// Self-checking bench for axi_pwm_lite_slave: register map, handshakes,
// strobes, read/write collision, PWM waveform shapes and reset behaviour.
module tb_axi_pwm_lite_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid, pwm_out;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int passed = 0;

  // Reference register contents, maintained from the bench's own writes
  logic [31:0] mreg [4];
  // Captured pwm_out samples, one per falling clock edge
  logic        samp [64];

  always #5 clk = ~clk;

  axi_pwm_lite_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .pwm_out       (pwm_out)
  );

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) mreg[a[3:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_go, w_go;
    int   cyc;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    cyc = 0;
    while ((awvalid || wvalid) && cyc < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk); cyc++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
    end
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00)
      $display("FAIL write_resp addr=%h: bvalid=%b bresp=%b, want bvalid=1 bresp=00", a, bvalid, bresp);
    else passed++;
    @(negedge clk);
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] r);
    logic go;
    int   cyc;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    cyc = 0;
    while (arvalid && cyc < 50) begin
      go = arready;
      @(negedge clk); cyc++;
      if (go) arvalid = 1'b0;
    end
    cyc = 0;
    while (!rvalid && cyc < 50) begin @(negedge clk); cyc++; end
    d = rvalid ? rdata : 32'hxxxx_xxxx;
    r = rvalid ? rresp : 2'bxx;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0; arvalid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      samp[i] = pwm_out;
    end
  endtask

  function automatic int find_edge(input logic rising, input int n);
    for (int i = 1; i < n; i++)
      if (samp[i-1] === !rising && samp[i] === rising) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, pwm_out} !== '0)
      $display("FAIL reset_outputs: aw/w/ar_ready=%b%b%b bvalid=%b rvalid=%b rdata=%h pwm=%b, want all 0",
               awready, wready, arready, bvalid, rvalid, rdata, pwm_out);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL reset_release_ready: got %b%b%b, want 111", awready, wready, arready);
    else passed++;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
  endtask

  task automatic test_regmap();
    logic [31:0] d; logic [1:0] r;
    for (int i = 0; i < 4; i++) axi_write(4'(i*4), 32'(i+1), 4'hF);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i*4), d, r);
      checks++;
      if ({r, d} !== {2'b00, 32'(i+1)})
        $display("FAIL regmap_read[%0d]: rdata=%h rresp=%b, want %h/00", i, d, r, 32'(i+1));
      else passed++;
    end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r;
    axi_write(4'hC, 32'hAABB_CCDD, 4'hF);
    axi_write(4'hC, 32'h1122_3344, 4'h5);
    axi_read(4'hC, d, r);
    checks++;
    if (d !== 32'hAA22_CC44)
      $display("FAIL strobe_merge: rdata=%h, want aa22cc44", d);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] d, v; logic [1:0] r; logic [3:0] a, s;
    int bad = 0;
    for (int i = 0; i < 24; i++) begin
      a = 4'($urandom_range(0, 15));
      v = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(a, v, s);
      a = 4'($urandom_range(0, 15));
      axi_read(a, d, r);
      checks++;
      if (d !== mreg[a[3:2]] || r !== 2'b00) begin
        bad++;
        $display("FAIL random_read addr=%h: rdata=%h rresp=%b, want %h/00", a, d, r, mreg[a[3:2]]);
      end else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r;
    int mism;
    @(negedge clk);
    awaddr = 4'h4; awvalid = 1'b1;
    checks++;
    if (awready !== 1'b1) $display("FAIL b2b_aw_ready: awready=%b, want 1", awready);
    else passed++;
    @(negedge clk);
    awvalid = 1'b0;
    mism = 0;
    for (int k = 0; k < 3; k++) begin
      if (awready !== 1'b0 || bvalid !== 1'b0) mism++;
      @(negedge clk);
    end
    checks++;
    if (mism != 0) $display("FAIL b2b_aw_held: %0d cycles with awready/bvalid high, want 0", mism);
    else passed++;
    wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1) $display("FAIL b2b_bvalid_rise: bvalid=%b, want 1", bvalid);
    else passed++;
    awaddr = 4'h8; wdata = 32'h0000_DEAD; awvalid = 1'b1; wvalid = 1'b1;
    mism = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) mism++;
    end
    checks++;
    if (mism != 0) $display("FAIL b2b_stall: %0d cycles with bvalid low or aw/wready high, want 0", mism);
    else passed++;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) $display("FAIL b2b_bvalid_drop: bvalid=%b, want 0", bvalid);
    else passed++;
    model_write(4'h4, 32'h0000_0055, 4'hF);
    axi_read(4'h4, d, r);
    checks++;
    if (d !== 32'h0000_0055) $display("FAIL b2b_period: rdata=%h, want 00000055", d);
    else passed++;
    axi_read(4'h8, d, r);
    checks++;
    if (d !== mreg[2]) $display("FAIL b2b_no_second_write: rdata=%h, want %h", d, mreg[2]);
    else passed++;
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r;
    axi_write(4'hC, 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111)
      $display("FAIL coll_ready: got %b%b%b, want 111", awready, wready, arready);
    else passed++;
    awaddr = 4'hC; wdata = 32'h600D_CAFE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; araddr = 4'hD; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if ({bvalid, rvalid, rdata} !== {1'b1, 1'b1, 32'h0BAD_F00D})
      $display("FAIL coll_old_value: bvalid=%b rvalid=%b rdata=%h, want 1/1/0badf00d", bvalid, rvalid, rdata);
    else passed++;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    model_write(4'hC, 32'h600D_CAFE, 4'hF);
    axi_read(4'hC, d, r);
    checks++;
    if (d !== 32'h600D_CAFE) $display("FAIL coll_new_value: rdata=%h, want 600dcafe", d);
    else passed++;
  endtask

  task automatic test_pwm_basic();
    int e, mism;
    axi_write(4'h0, 32'h0, 4'hF);
    axi_write(4'h4, 32'd10, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    capture(45);
    e = find_edge(1'b1, 45);
    checks++;
    if (e < 1 || e > 20) $display("FAIL pwm_basic_rise: rise index %0d, want 1..20", e);
    else begin
      passed++;
      mism = 0;
      for (int j = 0; j < 20; j++) if (samp[e+j] !== ((j % 10) < 3)) mism++;
      checks++;
      if (mism != 0) $display("FAIL pwm_basic_shape: %0d samples off 3-high/7-low, want 0", mism);
      else passed++;
    end
  endtask

  task automatic test_pwm_midperiod();
    int e, mism;
    fork
      capture(60);
      begin
        logic prev, cur;
        prev = 1'b0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          cur = pwm_out;
          if (prev && !cur) break;
          prev = cur;
        end
        axi_write(4'h8, 32'd7, 4'hF);
      end
    join
    e = find_edge(1'b0, 60);
    checks++;
    if (e < 1 || e > 25) $display("FAIL pwm_mid_fall: fall index %0d, want 1..25", e);
    else begin
      passed++;
      mism = 0;
      for (int j = 0; j < 27; j++)
        if (samp[e+j] !== ((j < 7) ? 1'b0 : (((j - 7) % 10) < 7))) mism++;
      checks++;
      if (mism != 0) $display("FAIL pwm_mid_shape: %0d samples off (old period finish then 7-high), want 0", mism);
      else passed++;
    end
  endtask

  task automatic test_pwm_invert();
    int e, mism;
    axi_write(4'h0, 32'h3, 4'hF);
    repeat (15) @(negedge clk);
    capture(40);
    e = find_edge(1'b1, 40);
    checks++;
    if (e < 1 || e > 20) $display("FAIL pwm_inv_rise: rise index %0d, want 1..20", e);
    else begin
      passed++;
      mism = 0;
      for (int j = 0; j < 20; j++) if (samp[e+j] !== ((j % 10) < 3)) mism++;
      checks++;
      if (mism != 0) $display("FAIL pwm_inv_shape: %0d samples off 3-high/7-low, want 0", mism);
      else passed++;
    end
  endtask

  task automatic test_pwm_bounds();
    int mism;
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h8, 32'd12, 4'hF);
    repeat (25) @(negedge clk);
    capture(20);
    mism = 0;
    for (int j = 0; j < 20; j++) if (samp[j] !== 1'b1) mism++;
    checks++;
    if (mism != 0) $display("FAIL pwm_duty_ge_period: %0d low samples, want 0", mism);
    else passed++;
    axi_write(4'h0, 32'h0, 4'hF);
    @(negedge clk);
    mism = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || dut.u_pwm.cnt !== '0) mism++;
    end
    checks++;
    if (mism != 0) $display("FAIL pwm_disabled: %0d cycles with pwm_out or counter nonzero, want 0", mism);
    else passed++;
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    repeat (25) @(negedge clk);
    capture(20);
    mism = 0;
    for (int j = 0; j < 20; j++) if (samp[j] !== 1'b0) mism++;
    checks++;
    if (mism != 0) $display("FAIL pwm_period_zero: %0d high samples, want 0", mism);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic [1:0] r;
    logic aw_go, w_go, ar_go;
    int cyc;
    axi_write(4'h4, 32'd10, 4'hF);
    repeat (15) @(negedge clk);
    checks++;
    if (pwm_out !== 1'b1) $display("FAIL rst_pre_pwm: pwm_out=%b, want 1", pwm_out);
    else passed++;
    awaddr = 4'hC; wdata = 32'h1234_5678; wstrb = 4'hF; araddr = 4'h4;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    cyc = 0;
    while (!(bvalid && rvalid) && cyc < 20) begin
      aw_go = awvalid && awready; w_go = wvalid && wready; ar_go = arvalid && arready;
      @(negedge clk); cyc++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      if (ar_go) arvalid = 1'b0;
    end
    checks++;
    if ({bvalid, rvalid} !== 2'b11) $display("FAIL rst_pre_valids: bvalid=%b rvalid=%b, want 11", bvalid, rvalid);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bvalid, rvalid, pwm_out, awready, arready} !== 5'b0)
      $display("FAIL rst_async_drop: bvalid=%b rvalid=%b pwm=%b awready=%b arready=%b, want all 0",
               bvalid, rvalid, pwm_out, awready, arready);
    else passed++;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i*4), d, r);
      checks++;
      if (d !== mreg[i]) $display("FAIL rst_clear[%0d]: rdata=%h, want %h", i, d, mreg[i]);
      else passed++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time (%0d/%0d)", passed, checks);
    $fatal(1);
  end

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    wdata = '0; wstrb = '0;
    rst_n = 1'b0;
    test_reset();
    test_regmap();
    test_strobe();
    test_random();
    test_back_to_back();
    test_collision();
    test_pwm_basic();
    test_pwm_midperiod();
    test_pwm_invert();
    test_pwm_bounds();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
